// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage that requests instructions on a single-beat bus and presents them to IF/ID
//   clk, rst                       : clock, async active-high reset
//   stall[5:0], flush, new_pc      : pipeline control (stall[1] stops IF/ID), exception redirect
//   branch_flag_i, branch_target_i : taken branch from ID, sampled when an instruction is consumed
//   ibus_req_o/addr_o/ack_i/rdata_i: instruction bus, ack and data valid in the same cycle
//   if_pc, if_inst                 : presented instruction, zero when nothing is valid
//   stallreq_if                    : asks ctrl to stall while a fetch is pending
//   IF_ADEL_EN                     : adds if_adel_o, raised for a misaligned fetch PC until flush
module if_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
`ifdef IF_ADEL_EN
  ,
  output logic        if_adel_o
`endif
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, CANCEL} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, hold_pc_q, hold_pc_d, hold_inst_q, hold_inst_d, cancel_addr_q, cancel_addr_d;
  logic [31:0] seq_pc, addr_raw;
  logic misal, fetch_ack, unused_ok;
  assign unused_ok = ^{stall[5:2], stall[0], addr_raw[1:0]};
`ifdef IF_ADEL_EN
  assign if_adel_o = misal;
`endif
  always_comb begin
    misal = 1'b0;
`ifdef IF_ADEL_EN
    misal = (state_q == FETCH) && (pc_q[1:0] != 2'b00);
`endif
    fetch_ack = (state_q == FETCH) && !misal && ibus_ack_i;
    seq_pc = branch_flag_i ? branch_target_i : pc_q + 32'd4;
    ibus_req_o = ((state_q == FETCH) && !misal) || (state_q == CANCEL);
    // a cancelled request keeps the address the bus was given, not the redirected pc
    addr_raw = (state_q == CANCEL) ? cancel_addr_q : pc_q;
`ifdef IF_ADEL_EN
    ibus_addr_o = addr_raw;
`else
    ibus_addr_o = {addr_raw[31:2], 2'b00};
`endif
    stallreq_if = (state_q == CANCEL) || ((state_q == FETCH) && !misal && !ibus_ack_i);
    if_pc = fetch_ack ? pc_q : (state_q == HOLD) ? hold_pc_q : misal ? pc_q : 32'd0;
    if_inst = fetch_ack ? ibus_rdata_i : (state_q == HOLD) ? hold_inst_q : 32'd0;
    state_d = state_q;
    pc_d = pc_q;
    hold_pc_d = hold_pc_q;
    hold_inst_d = hold_inst_q;
    cancel_addr_d = cancel_addr_q;
    if (flush) begin
      pc_d = new_pc;
      hold_pc_d = 32'd0;
      hold_inst_d = 32'd0;
      // an unacked request must still complete on the bus; its data is dropped in CANCEL
      if ((state_q == FETCH) && ibus_req_o && !ibus_ack_i) begin
        state_d = CANCEL;
        cancel_addr_d = pc_q;
      end else
        state_d = ((state_q == CANCEL) && !ibus_ack_i) ? CANCEL : FETCH;
    end else if (state_q == IDLE)
      state_d = FETCH;
    else if (fetch_ack) begin
      if (stall[1]) begin
        hold_pc_d = pc_q;
        hold_inst_d = ibus_rdata_i;
        state_d = HOLD;
      end else
        pc_d = seq_pc;
    end else if ((state_q == HOLD) && !stall[1]) begin
      pc_d = seq_pc;
      state_d = FETCH;
    end else if ((state_q == CANCEL) && ibus_ack_i)
      state_d = FETCH;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      pc_q <= 32'd0;
      hold_pc_q <= 32'd0;
      hold_inst_q <= 32'd0;
      cancel_addr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      hold_pc_q <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
      cancel_addr_q <= cancel_addr_d;
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed stimulus with a transaction-level fetch model checked every cycle
module tb_if_fetch;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [5:0] stall;
  logic flush, br, ack_en;
  logic [31:0] new_pc, tgt;
  logic ibus_req_o, ibus_ack_i, stallreq_if;
  logic [31:0] ibus_addr_o, ibus_rdata_i, if_pc, if_inst;
`ifdef IF_ADEL_EN
  logic if_adel_o;
`endif
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[7:0], 24'h0};
  endfunction
  assign ibus_ack_i = ack_en & ibus_req_o;
  assign ibus_rdata_i = mem(ibus_addr_o);
  if_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(br), .branch_target_i(tgt),
    .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o), .ibus_ack_i(ibus_ack_i), .ibus_rdata_i(ibus_rdata_i),
    .if_pc(if_pc), .if_inst(if_inst), .stallreq_if(stallreq_if)
`ifdef IF_ADEL_EN
    , .if_adel_o(if_adel_o)
`endif
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
    end
  endtask
  // model: what the fetch unit owes the pipeline, kept as flags rather than a state code
  logic m_run = 1'b0, m_held = 1'b0, m_cancel = 1'b0;
  logic [31:0] m_pc = 0, m_hpc = 0, m_hinst = 0, m_caddr = 0;
  always @(negedge clk) begin
    logic mis, e_req, e_ack, e_stall;
    logic [31:0] e_addr, e_pc, e_inst, nxt;
    mis = 1'b0;
`ifdef IF_ADEL_EN
    mis = m_run && !m_held && !m_cancel && (m_pc[1:0] != 2'b00);
    e_addr = m_cancel ? m_caddr : m_pc;
`else
    e_addr = m_cancel ? {m_caddr[31:2], 2'b00} : {m_pc[31:2], 2'b00};
`endif
    e_req = !rst && m_run && !m_held && !mis;
    e_ack = e_req && ack_en;
    e_stall = e_req && (m_cancel || !e_ack);
    e_pc = 0;
    e_inst = 0;
    if (!rst && m_held) begin e_pc = m_hpc; e_inst = m_hinst; end
    else if (e_ack && !m_cancel) begin e_pc = m_pc; e_inst = mem(e_addr); end
    else if (!rst && mis) e_pc = m_pc;
    chk("req", {31'd0, ibus_req_o}, {31'd0, e_req});
    if (e_req) chk("addr", ibus_addr_o, e_addr);
    chk("stallreq", {31'd0, stallreq_if}, {31'd0, e_stall});
    chk("if_pc", if_pc, e_pc);
    chk("if_inst", if_inst, e_inst);
`ifdef IF_ADEL_EN
    chk("adel", {31'd0, if_adel_o}, {31'd0, mis});
`endif
    nxt = br ? tgt : m_pc + 32'd4;
    if (rst) begin
      m_run = 0; m_held = 0; m_cancel = 0; m_pc = 0;
    end else if (!m_run) begin
      m_run = 1;
      if (flush) m_pc = new_pc;
    end else if (flush) begin
      if (m_cancel ? !e_ack : (e_req && !e_ack)) begin
        if (!m_cancel) m_caddr = m_pc;
        m_cancel = 1;
      end else m_cancel = 0;
      m_held = 0;
      m_pc = new_pc;
    end else if (m_cancel) begin
      if (e_ack) m_cancel = 0;
    end else if (m_held) begin
      if (!stall[1]) begin m_held = 0; m_pc = nxt; end
    end else if (e_ack) begin
      if (stall[1]) begin m_held = 1; m_hpc = m_pc; m_hinst = mem(e_addr); end
      else m_pc = nxt;
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    stall = 0; flush = 0; new_pc = 0; br = 0; tgt = 0; ack_en = 1;
    #2 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst req", {31'd0, ibus_req_o}, 32'd0);
    chk("rst if_inst", if_inst, 32'd0);
    rst = 0;
    cyc;
    @(negedge clk); chk("first addr", ibus_addr_o, 32'h0); chk("first inst", if_inst, 32'hC0DE0000);
    cyc;
    @(negedge clk); chk("second addr", ibus_addr_o, 32'h4);
    cyc;
    @(negedge clk); chk("third addr", ibus_addr_o, 32'h8); chk("no stallreq", {31'd0, stallreq_if}, 32'd0);
    cyc; cyc; ack_en = 0;
    repeat (3) begin
      @(negedge clk);
      chk("wait stallreq", {31'd0, stallreq_if}, 32'd1);
      chk("wait addr", ibus_addr_o, 32'h10);
      chk("wait inst", if_inst, 32'd0);
      cyc;
    end
    ack_en = 1;
    @(negedge clk); chk("late ack pc", if_pc, 32'h10); chk("late ack stallreq", {31'd0, stallreq_if}, 32'd0);
    repeat (4) cyc;
    stall = 6'b000010;
    @(negedge clk); chk("hold entry pc", if_pc, 32'h20);
    cyc;
    @(negedge clk); chk("hold req", {31'd0, ibus_req_o}, 32'd0); chk("hold pc", if_pc, 32'h20);
    cyc; stall = 0;
    @(negedge clk); chk("hold pc 2", if_pc, 32'h20);
    cyc;
    @(negedge clk); chk("after hold addr", ibus_addr_o, 32'h24);
    repeat (7) cyc;
    br = 1; tgt = 32'h100;
    @(negedge clk); chk("delay slot pc", if_pc, 32'h40);
    cyc; tgt = 32'h50;
    @(negedge clk); chk("branch addr", ibus_addr_o, 32'h100);
    cyc; br = 0; ack_en = 0;
    @(negedge clk); chk("pend addr", ibus_addr_o, 32'h50);
    cyc; flush = 1; new_pc = 32'h180;
    cyc; flush = 0;
    @(negedge clk); chk("cancel addr", ibus_addr_o, 32'h50); chk("cancel stallreq", {31'd0, stallreq_if}, 32'd1);
    cyc; ack_en = 1;
    @(negedge clk); chk("cancel discard", if_inst, 32'd0);
    cyc;
    @(negedge clk); chk("handler addr", ibus_addr_o, 32'h180); chk("handler inst", if_inst, 32'h40DE0180);
    cyc; flush = 1; new_pc = 32'h200;
    cyc; flush = 0;
    @(negedge clk); chk("flush ack addr", ibus_addr_o, 32'h200);
    cyc; stall = 6'b000010;
    cyc; flush = 1; new_pc = 32'h300;
    cyc; flush = 0; stall = 0;
    @(negedge clk); chk("flush hold addr", ibus_addr_o, 32'h300);
    cyc; br = 1; tgt = 32'hFFFF_FFFC;
    cyc; br = 0;
    @(negedge clk); chk("top addr", ibus_addr_o, 32'hFFFF_FFFC);
    cyc;
    @(negedge clk); chk("wrap addr", ibus_addr_o, 32'h0);
    cyc; br = 1; tgt = 32'h102;
    cyc; br = 0;
`ifdef IF_ADEL_EN
    @(negedge clk); chk("adel flag", {31'd0, if_adel_o}, 32'd1); chk("adel pc", if_pc, 32'h102);
    chk("adel req", {31'd0, ibus_req_o}, 32'd0);
    cyc; flush = 1; new_pc = 32'h180;
    cyc; flush = 0;
    @(negedge clk); chk("adel cleared", {31'd0, if_adel_o}, 32'd0); chk("adel flush addr", ibus_addr_o, 32'h180);
`else
    @(negedge clk); chk("masked addr", ibus_addr_o, 32'h100);
    cyc;
    @(negedge clk); chk("masked next", ibus_addr_o, 32'h104);
`endif
    cyc; ack_en = 0;
    cyc; rst = 1;
    #1; chk("async rst req", {31'd0, ibus_req_o}, 32'd0); chk("async rst stallreq", {31'd0, stallreq_if}, 32'd0);
    cyc; rst = 0; ack_en = 1;
    cyc;
    @(negedge clk); chk("restart addr", ibus_addr_o, 32'h0);
    cyc;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 SHALL expose ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  async active-high reset
- stall  in  6  pipeline stall vector from ctrl; bit1 = IF/ID stop
- flush  in  1  exception flush, 1-cycle pulse
- new_pc  in  32  exception handler address, valid with flush
- branch_flag_i  in  1  ID branch taken
- branch_target_i  in  32  ID branch target
- ibus_req_o  out  1  instruction bus request
- ibus_addr_o  out  32  instruction fetch address
- ibus_ack_i  in  1  bus ack, 1 cycle, rdata valid same cycle
- ibus_rdata_i  in  32  fetched instruction
- if_pc  out  32  PC of presented instruction
- if_inst  out  32  presented instruction
- stallreq_if  out  1  stall request to ctrl

Function
REQ-003 SHALL implement states IDLE, FETCH, HOLD, CANCEL.
REQ-004 SHALL keep a 32-bit fetch PC register `pc`; ibus_addr_o = pc in FETCH, the old address in CANCEL.
REQ-005 SHALL move IDLE -> FETCH on the first clock edge after rst deasserts.
REQ-006 SHALL assert ibus_req_o in FETCH and CANCEL only; address held stable until ack.
REQ-007 SHALL drive stallreq_if = 1 in CANCEL, and in FETCH while ibus_ack_i = 0; 0 otherwise.
REQ-008 SHALL, in FETCH with ack, drive if_pc = pc and if_inst = ibus_rdata_i combinationally that cycle.
REQ-009 SHALL, in FETCH with ack and stall[1] = 0, consume: pc <= branch_flag_i ? branch_target_i : pc+4, stay in FETCH (1 instr/cycle with zero-wait memory).
REQ-010 SHALL, in FETCH with ack and stall[1] = 1, capture pc/rdata into a hold buffer and enter HOLD.
REQ-011 SHALL, in HOLD, drive if_pc/if_inst from the buffer, keep ibus_req_o = 0, and consume (REQ-009 PC update, -> FETCH) at the first edge with stall[1] = 0.
REQ-012 SHALL sample branch_flag_i/branch_target_i only at the consume edge; the delay-slot instruction is never discarded by a branch.
REQ-013 SHALL give flush top priority: pc <= new_pc; FETCH without ack -> CANCEL; FETCH with ack, HOLD, or CANCEL with ack -> FETCH; hold buffer discarded.
REQ-014 SHALL, in CANCEL, keep the request until ack, discard rdata, then -> FETCH at new_pc.
REQ-015 SHALL drive if_pc = 0 and if_inst = 0 in IDLE, CANCEL, and FETCH without ack.
REQ-016 SHALL compute pc+4 modulo 2^32 (0xFFFFFFFC -> 0x00000000).

Reset
REQ-017 SHALL on rst: state IDLE, pc = 0x00000000, hold buffer = 0, ibus_req_o = 0, stallreq_if = 0, if_pc = if_inst = 0.
REQ-018 SHALL abandon any outstanding bus request on reset; the bus is reset by the same rst.

Configuration
REQ-019 SHALL support macro IF_ADEL_EN.
REQ-020 With IF_ADEL_EN defined: output if_adel_o (1 bit); if pc[1:0] != 0 in FETCH, no request issued, stallreq_if = 0, if_pc = pc, if_inst = 0, if_adel_o = 1 until flush.
REQ-021 Without IF_ADEL_EN: no if_adel_o port; ibus_addr_o[1:0] forced to 00.

Verification
REQ-022 Reset release, ack tied high, stall = 0 -> addresses 0x0, 0x4, 0x8 on consecutive cycles, if_inst = rdata each cycle, stallreq_if = 0.
REQ-023 Ack delayed 3 cycles at 0x10 -> stallreq_if = 1 for 3 cycles, addr held 0x10, if_inst = 0 until ack cycle.
REQ-024 Ack at 0x20 with stall[1] = 1 for 2 cycles -> HOLD, ibus_req_o = 0, if_pc = 0x20 held; next request 0x24 after stall drops.
REQ-025 branch_flag_i = 1, target 0x100, consume at 0x40 -> next address 0x100; 0x40 instruction presented.
REQ-026 flush with new_pc 0x180 while 0x50 outstanding -> CANCEL, 0x50 data discarded, next request 0x180.
REQ-027 IF_ADEL_EN, branch target 0x102 -> no request, if_adel_o = 1, if_pc = 0x102; flush to 0x180 clears it.
